// File: rtl/pong_pkg.sv
// Shared encodings and widths for the Pong game controller.
package pong_pkg;

   localparam int unsigned BCD_W   = 8;
   localparam int unsigned TIMER_W = 7;

   typedef enum logic [1:0] {
      ST_NEWGAME = 2'b00,
      ST_PLAY    = 2'b01,
      ST_NEWBALL = 2'b10,
      ST_OVER    = 2'b11
   } state_t;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter (00..99, wraps); clr has priority over inc.
module bcd_counter2
   import pong_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] count
);

   logic [3:0] ones_q;
   logic [3:0] tens_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ones_q <= 4'd0;
         tens_q <= 4'd0;
      end else if (clr) begin
         ones_q <= 4'd0;
         tens_q <= 4'd0;
      end else if (inc) begin
         if (ones_q == 4'd9) begin
            ones_q <= 4'd0;
            tens_q <= (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
         end else begin
            ones_q <= ones_q + 4'd1;
         end
      end
   end

   assign count = {tens_q, ones_q};

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: play/freeze FSM, ball reserve, pause timer and BCD score.
// Optional high-score register enabled by PONG_CTRL_HISCORE_EN.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned BALLS_INIT   = 3,
   parameter int unsigned TIMER_FRAMES = 120
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic [1:0]       button,
   input  logic             hit,
   input  logic             miss,
   output logic             gra_still,
   output logic [1:0]       game_state,
   output logic [1:0]       balls_left,
   output logic [BCD_W-1:0] score_bcd,
   output logic [BCD_W-1:0] hiscore_bcd
);

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [1:0]           balls_q, balls_d;
   logic                 score_clr;
   logic                 score_inc;

   // Next-state, timer, reserve and score control
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      balls_d   = balls_q;
      score_clr = 1'b0;
      score_inc = 1'b0;
      case (state_q)
         ST_NEWGAME: begin
            score_clr = 1'b1;
            if (button != 2'b00) begin
               state_d = ST_PLAY;
               balls_d = balls_q - 2'd1;
            end
         end
         ST_PLAY: begin
            if (miss) begin
               timer_d = TIMER_W'(TIMER_FRAMES);
               state_d = (balls_q != 2'd0) ? ST_NEWBALL : ST_OVER;
            end else if (hit) begin
               score_inc = 1'b1;
            end
         end
         ST_NEWBALL: begin
            if (timer_q == '0) begin
               if (button != 2'b00) begin
                  state_d = ST_PLAY;
                  if (balls_q != 2'd0) begin
                     balls_d = balls_q - 2'd1;
                  end
               end
            end else if (frame_tick) begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_OVER: begin
            if (timer_q == '0) begin
               state_d   = ST_NEWGAME;
               score_clr = 1'b1;
               balls_d   = 2'(BALLS_INIT);
            end else if (frame_tick) begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: begin
            state_d = ST_NEWGAME;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_NEWGAME;
         timer_q   <= '0;
         balls_q   <= 2'(BALLS_INIT);
         gra_still <= 1'b1;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         balls_q   <= balls_d;
         gra_still <= (state_d != ST_PLAY);
      end
   end

   assign game_state = state_q;
   assign balls_left = balls_q;

   bcd_counter2 u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (score_clr),
      .inc   (score_inc),
      .count (score_bcd)
   );

`ifdef PONG_CTRL_HISCORE_EN
   logic [BCD_W-1:0] hiscore_q;
   logic             enter_over;

   assign enter_over = (state_q == ST_PLAY) && (state_d == ST_OVER);

   // BCD digits compare correctly as a plain unsigned byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hiscore_q <= '0;
      end else if (enter_over && (score_bcd > hiscore_q)) begin
         hiscore_q <= score_bcd;
      end
   end

   assign hiscore_bcd = hiscore_q;
`else
   assign hiscore_bcd = '0;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl against a decimal-score game model.
module tb_pong_game_ctrl;

   localparam int unsigned BI = 3;
   localparam int unsigned TF = 120;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic [1:0] button;
   logic       hit;
   logic       miss;
   logic       gra_still;
   logic [1:0] game_state;
   logic [1:0] balls_left;
   logic [7:0] score_bcd;
   logic [7:0] hiscore_bcd;

   int total = 0;
   int bad   = 0;

   // model: 0=newgame 1=play 2=newball 3=over; score as integer 0..99
   int m_state, m_score, m_balls, m_timer, m_hi;

   always #5 clk = ~clk;

   pong_game_ctrl #(.BALLS_INIT(BI), .TIMER_FRAMES(TF)) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .button      (button),
      .hit         (hit),
      .miss        (miss),
      .gra_still   (gra_still),
      .game_state  (game_state),
      .balls_left  (balls_left),
      .score_bcd   (score_bcd),
      .hiscore_bcd (hiscore_bcd)
   );

   wire [20:0] dut_vec = {game_state, gra_still, balls_left, score_bcd, hiscore_bcd};

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [20:0] exp_vec();
      logic [7:0] hi;
`ifdef PONG_CTRL_HISCORE_EN
      hi = to_bcd(m_hi);
`else
      hi = 8'h00;
`endif
      return {2'(m_state), (m_state != 1), 2'(m_balls), to_bcd(m_score), hi};
   endfunction

   task automatic model_reset();
      m_state = 0; m_score = 0; m_balls = BI; m_timer = 0; m_hi = 0;
   endtask

   task automatic model_update();
      case (m_state)
         0: begin
            m_score = 0;
            if (button != 0) begin m_state = 1; m_balls = m_balls - 1; end
         end
         1: begin
            if (miss) begin
               m_timer = TF;
               if (m_balls != 0) m_state = 2;
               else begin
                  m_state = 3;
                  if (m_score > m_hi) m_hi = m_score;
               end
            end else if (hit) begin
               m_score = (m_score + 1) % 100;
            end
         end
         2: begin
            if (m_timer == 0) begin
               if (button != 0) begin m_state = 1; m_balls = m_balls - 1; end
            end else if (frame_tick) m_timer = m_timer - 1;
         end
         default: begin
            if (m_timer == 0) begin
               m_state = 0; m_score = 0; m_balls = BI;
            end else if (frame_tick) m_timer = m_timer - 1;
         end
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else model_update();
      #1;
   endtask

   task automatic clear_inputs();
      frame_tick = 1'b0; button = 2'b00; hit = 1'b0; miss = 1'b0;
   endtask

   task automatic pulse_hit();
      hit = 1'b1; step(); hit = 1'b0;
   endtask

   task automatic pulse_miss();
      miss = 1'b1; step(); miss = 1'b0;
   endtask

   // Drive ticks with button held until the model is back in PLAY
   task automatic run_pause();
      int n = 0;
      button = 2'b11;
      while (m_state != 1 && n < 600) begin
         frame_tick = 1'b1; step(); n++;
      end
      clear_inputs();
      total++;
      if (m_state != 1) begin
         bad++;
         $display("FAIL run_pause_timeout cycles=%0d model_state=%0d", n, m_state);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 1000; i++) begin
         hit = 1'($urandom_range(0, 1));
         miss = 1'($urandom_range(0, 1));
         frame_tick = 1'($urandom_range(0, 1));
         step();
         total++;
         if (dut_vec !== 21'({2'd0, 1'b1, 2'd3, 8'h00, 8'h00}) || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
      clear_inputs();
   endtask

   task automatic test_start_score();
      button = 2'b01; step(); button = 2'b00;
      total++;
      if (game_state !== 2'd1 || gra_still !== 1'b0 || balls_left !== 2'd2) begin
         bad++;
         $display("FAIL start st=%0d still=%b balls=%0d exp 1/0/2", game_state, gra_still, balls_left);
      end
      for (int i = 0; i < 12; i++) begin
         pulse_hit();
         repeat ($urandom_range(0, 2)) begin
            button = 2'($urandom); frame_tick = 1'($urandom); step();
         end
         clear_inputs();
      end
      total++;
      if (score_bcd !== 8'h12 || dut_vec !== exp_vec()) begin
         bad++;
         $display("FAIL score_12 got=%h exp=12 vec=%h exp_vec=%h", score_bcd, dut_vec, exp_vec());
      end
      for (int i = 0; i < 88; i++) begin
         pulse_hit();
         if (i == 86) begin
            total++;
            if (score_bcd !== 8'h99) begin
               bad++;
               $display("FAIL score_99 got=%h exp=99", score_bcd);
            end
         end
         if ($urandom_range(0, 1) == 1) step();
      end
      total++;
      if (score_bcd !== 8'h00 || dut_vec !== exp_vec()) begin
         bad++;
         $display("FAIL score_wrap got=%h exp=00", score_bcd);
      end
   endtask

   task automatic test_newball_pause();
      pulse_miss();
      total++;
      if (game_state !== 2'd2 || gra_still !== 1'b1 || balls_left !== 2'd2) begin
         bad++;
         $display("FAIL miss_to_newball st=%0d still=%b balls=%0d exp 2/1/2", game_state, gra_still, balls_left);
      end
      button = 2'b10;
      for (int i = 0; i < 119; i++) begin
         frame_tick = 1'b1; step(); frame_tick = 1'b0;
         repeat ($urandom_range(0, 1)) step();
         total++;
         if (game_state !== 2'd2 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL pause_hold tick=%0d st=%0d exp=2", i + 1, game_state);
         end
      end
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      total++;
      if (game_state !== 2'd2) begin
         bad++;
         $display("FAIL pause_tick120 st=%0d exp=2", game_state);
      end
      step();
      total++;
      if (game_state !== 2'd1 || balls_left !== 2'd1 || gra_still !== 1'b0) begin
         bad++;
         $display("FAIL pause_restart st=%0d balls=%0d still=%b exp 1/1/0", game_state, balls_left, gra_still);
      end
      clear_inputs();
   endtask

   task automatic test_hit_miss_same();
      for (int i = 0; i < 7; i++) pulse_hit();
      total++;
      if (score_bcd !== 8'h07) begin
         bad++;
         $display("FAIL score_07 got=%h exp=07", score_bcd);
      end
      hit = 1'b1; miss = 1'b1; step(); clear_inputs();
      total++;
      if (score_bcd !== 8'h07 || game_state !== 2'd2 || balls_left !== 2'd1) begin
         bad++;
         $display("FAIL hit_miss_same score=%h st=%0d balls=%0d exp 07/2/1", score_bcd, game_state, balls_left);
      end
   endtask

   task automatic test_game_over();
      run_pause();
      total++;
      if (game_state !== 2'd1 || balls_left !== 2'd0) begin
         bad++;
         $display("FAIL last_ball st=%0d balls=%0d exp 1/0", game_state, balls_left);
      end
      pulse_miss();
      total++;
      if (game_state !== 2'd3 || gra_still !== 1'b1 || balls_left !== 2'd0) begin
         bad++;
         $display("FAIL enter_over st=%0d balls=%0d exp 3/0", game_state, balls_left);
      end
      for (int i = 0; i < 120; i++) begin
         frame_tick = 1'b1; button = 2'($urandom); step(); clear_inputs();
         if ($urandom_range(0, 2) == 0) step();
      end
      total++;
      if (game_state !== 2'd3 || score_bcd !== 8'h07) begin
         bad++;
         $display("FAIL over_tick120 st=%0d score=%h exp 3/07", game_state, score_bcd);
      end
      step();
      total++;
      if (game_state !== 2'd0 || score_bcd !== 8'h00 || balls_left !== 2'd3 || dut_vec !== exp_vec()) begin
         bad++;
         $display("FAIL over_to_newgame st=%0d score=%h balls=%0d exp 0/00/3", game_state, score_bcd, balls_left);
      end
   endtask

   task automatic test_reset_midgame();
      button = 2'b01; step(); clear_inputs();
      for (int i = 0; i < 4; i++) pulse_hit();
      pulse_miss();
      for (int i = 0; i < 70; i++) begin
         frame_tick = 1'b1; step(); frame_tick = 1'b0;
      end
      total++;
      if (game_state !== 2'd2 || m_timer != 50) begin
         bad++;
         $display("FAIL pre_reset st=%0d model_timer=%0d exp 2/50", game_state, m_timer);
      end
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      total++;
      if (dut_vec !== 21'({2'd0, 1'b1, 2'd3, 8'h00, 8'h00}) || dut_vec !== exp_vec()) begin
         bad++;
         $display("FAIL async_reset got=%h exp=%h", dut_vec, exp_vec());
      end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_hiscore();
      logic [7:0] exp_hi;
`ifdef PONG_CTRL_HISCORE_EN
      exp_hi = 8'h25;
`else
      exp_hi = 8'h00;
`endif
      button = 2'b01; step(); clear_inputs();
      pulse_miss(); run_pause();
      pulse_miss(); run_pause();
      for (int i = 0; i < 25; i++) pulse_hit();
      pulse_miss();
      total++;
      if (game_state !== 2'd3 || hiscore_bcd !== exp_hi || dut_vec !== exp_vec()) begin
         bad++;
         $display("FAIL hiscore_over st=%0d hi=%h exp 3/%h", game_state, hiscore_bcd, exp_hi);
      end
      frame_tick = 1'b1;
      repeat (TF + 1) step();
      clear_inputs();
      step();
      total++;
      if (game_state !== 2'd0 || hiscore_bcd !== exp_hi || dut_vec !== exp_vec()) begin
         bad++;
         $display("FAIL hiscore_newgame st=%0d hi=%h exp 0/%h", game_state, hiscore_bcd, exp_hi);
      end
      reset = 1'b1; model_reset(); #1;
      total++;
      if (hiscore_bcd !== 8'h00) begin
         bad++;
         $display("FAIL hiscore_reset hi=%h exp=00", hiscore_bcd);
      end
      step(); reset = 1'b0; step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 5000; i++) begin
         button     = ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'b00;
         hit        = ($urandom_range(0, 3) == 0);
         miss       = ($urandom_range(0, 19) == 0);
         frame_tick = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b1;
            model_reset();
         end else begin
            reset = 1'b0;
         end
         step();
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      model_reset();
      test_reset();
      test_start_score();
      test_newball_pause();
      test_hit_miss_same();
      test_game_over();
      test_reset_midgame();
      test_hiscore();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
